// File: rtl/boot_pkg.sv
// ============================================================================
// boot_pkg : shared state, checksum and error-cause definitions for the
//            instruction-memory boot loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package boot_pkg;

   localparam logic [7:0] BOOT_HDR_BYTE = 8'hA5;
   localparam int unsigned CSUM_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_CSUM  = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } boot_state_e;

   // Cause codes, also usable as a debug LED pattern.
   typedef enum logic [1:0] {
      ERR_BAD_LEN = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_TIMEOUT = 2'd2
   } boot_err_e;

endpackage

`default_nettype wire

// File: rtl/boot_word_assembler.sv
// ============================================================================
// boot_word_assembler : packs bytes MSB-first into 32-bit words and keeps a
//                       running XOR of every payload byte.
// Revision : 1.0
// ============================================================================
`default_nettype none

module boot_word_assembler
   import boot_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_shift,
   input  logic [7:0]        i_byte,
   output logic [31:0]       o_word,
   output logic              o_word_ready,
   output logic [CSUM_W-1:0] o_csum
);

   logic [23:0]       shreg_q, shreg_d;
   logic [1:0]        idx_q,   idx_d;
   logic [CSUM_W-1:0] csum_q,  csum_d;

   always_comb begin
      shreg_d = shreg_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      if (i_clear) begin
         shreg_d = '0;
         idx_d   = '0;
         csum_d  = '0;
      end else if (i_shift) begin
         shreg_d = {shreg_q[15:0], i_byte};
         idx_d   = idx_q + 2'd1;
         csum_d  = csum_q ^ i_byte;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         idx_q   <= '0;
         csum_q  <= '0;
      end else begin
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         csum_q  <= csum_d;
      end
   end

   // The completed word includes the byte being accepted this cycle.
   assign o_word       = {shreg_q, i_byte};
   assign o_word_ready = i_shift && (idx_q == 2'd3);
   assign o_csum       = csum_q;

endmodule

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// imem_boot_loader : receives a framed byte stream, writes words into IMEM
//                    while holding the core, then releases it with a PC load.
//                    Optional inter-byte timeout: define BOOT_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned ADDR_W   = 6,
   parameter logic [7:0]  START_PC = 8'h00,
   parameter logic [7:0]  HDR_BYTE = BOOT_HDR_BYTE
`ifdef BOOT_TIMEOUT_EN
   ,
   parameter logic [23:0] TIMEOUT_CYC = 24'd5000000
`endif
)(
   input  logic              SYS_clk,
   input  logic              SYS_reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              imem_we,
   output logic              cpu_hold,
   output logic              cpu_load,
   output logic [7:0]        cpu_pc_val,
   output logic              boot_done,
   output logic              boot_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned CNT_W     = ADDR_W + 1;
   localparam logic [8:0]  MAX_WORDS = 9'(1 << ADDR_W);

   boot_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q,    we_d;
   logic              hold_q,  hold_d;
   logic              load_q,  load_d;
   logic              done_q,  done_d;
   logic              err_q,   err_d;
   logic [CNT_W-1:0]  wl_q,    wl_d;
   logic [CNT_W-1:0]  n_q,     n_d;
`ifdef BOOT_TIMEOUT_EN
   logic [23:0]       tmo_q,   tmo_d;
`endif

   logic              xfer;
   logic              asm_clear;
   logic              asm_shift;
   logic [31:0]       asm_word;
   logic              asm_word_ready;
   logic [CSUM_W-1:0] asm_csum;

   assign in_ready = (state_q != ST_WRITE);
   assign xfer     = in_valid && in_ready;

   boot_word_assembler u_asm (
      .clk          (SYS_clk),
      .rst_n        (SYS_reset),
      .i_clear      (asm_clear),
      .i_shift      (asm_shift),
      .i_byte       (in_data),
      .o_word       (asm_word),
      .o_word_ready (asm_word_ready),
      .o_csum       (asm_csum)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = 1'b0;
      hold_d    = hold_q;
      load_d    = 1'b0;
      done_d    = done_q;
      err_d     = err_q;
      wl_d      = wl_q;
      n_d       = n_q;
      asm_clear = 1'b0;
      asm_shift = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (xfer && (in_data == HDR_BYTE)) begin
               state_d = ST_LEN;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
               wl_d    = '0;
            end
         end
         ST_LEN: begin
            if (xfer) begin
               if ((in_data == 8'd0) || ({1'b0, in_data} > MAX_WORDS)) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d   = ST_DATA;
                  n_d       = CNT_W'(in_data);
                  addr_d    = '0;
                  asm_clear = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               asm_shift = 1'b1;
               if (asm_word_ready) begin
                  state_d = ST_WRITE;
                  we_d    = 1'b1;
                  wdata_d = asm_word;
                  wl_d    = wl_q + CNT_W'(1);
               end
            end
         end
         ST_WRITE: begin
            // The address advances after the strobe so the final word of a
            // full 2**ADDR_W frame wraps the pointer back to zero harmlessly.
            addr_d  = addr_q + ADDR_W'(1);
            state_d = (wl_q == n_q) ? ST_CSUM : ST_DATA;
         end
         ST_CSUM: begin
            if (xfer) begin
               if (in_data == asm_csum) begin
                  state_d = ST_DONE;
                  load_d  = 1'b1;
                  hold_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef BOOT_TIMEOUT_EN
      tmo_d = '0;
      if (!xfer && (state_q inside {ST_LEN, ST_DATA, ST_CSUM})) begin
         if (tmo_q == TIMEOUT_CYC - 24'd1) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
         end else begin
            tmo_d = tmo_q + 24'd1;
         end
      end
`endif
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         hold_q  <= 1'b1;
         load_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         wl_q    <= '0;
         n_q     <= '0;
`ifdef BOOT_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         hold_q  <= hold_d;
         load_q  <= load_d;
         done_q  <= done_d;
         err_q   <= err_d;
         wl_q    <= wl_d;
         n_q     <= n_d;
`ifdef BOOT_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign imem_we      = we_q;
   assign cpu_hold     = hold_q;
   assign cpu_load     = load_q;
   assign cpu_pc_val   = START_PC;
   assign boot_done    = done_q;
   assign boot_err     = err_q;
   assign words_loaded = wl_q;

endmodule

`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the pipelined CPU core. Receives a framed byte stream over a valid/ready link and assembles big-endian 32-bit words.
- Writes those words into instruction memory while holding the core stalled.
- On a good checksum, releases the core and pulses the PC-load interface with the start address.
- Supports reloading without a system reset.

Parameters:
ADDR_W, 6, IMEM word-address width (64 words, matching PC[7:2])
START_PC, 8'h00, byte address driven on cpu_pc_val at release
HDR_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 24'd5000000, inter-byte timeout in clocks (used only with BOOT_TIMEOUT_EN)

Ports:
SYS_clk  in  1  system clock
SYS_reset  in  1  asynchronous, active-low reset
in_data  in  8  received byte
in_valid  in  1  byte available
in_ready  out  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
imem_addr  out  ADDR_W  IMEM word address
imem_wdata  out  32  IMEM write data
imem_we  out  1  one-cycle IMEM write strobe
cpu_hold  out  1  1 = core held (drives core reset/stall)
cpu_load  out  1  one-cycle PC-load pulse at release
cpu_pc_val  out  8  PC load value (= START_PC)
boot_done  out  1  last frame loaded successfully
boot_err  out  1  last frame failed
words_loaded  out  ADDR_W+1  words written in the current/last frame

Behaviour:
- Reset (async, SYS_reset=0) values:
  - state IDLE; in_ready=1; cpu_hold=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_load=0, cpu_pc_val=START_PC.
  - boot_done=0, boot_err=0, words_loaded=0.
- States: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: discard every byte except HDR_BYTE. On HDR_BYTE go to LEN, and set cpu_hold=1, boot_done=0, boot_err=0, words_loaded=0.
- LEN: byte N = word count.
  - N==0 or N>2**ADDR_W -> ERR.
  - Otherwise latch N, clear the byte index, clear the XOR checksum, set imem_addr=0, and go to DATA.
- DATA:
  - Shift each byte into a 32-bit assembly register, MSB first; XOR it into the checksum.
  - After the 4th byte go to WRITE.
- WRITE (exactly 1 cycle):
  - in_ready=0, imem_we=1, imem_wdata=assembled word at imem_addr; words_loaded increments.
  - Next cycle: imem_addr increments. If words_loaded==N go to CSUM, else go to DATA.
- CSUM: one byte.
  - Equal to the running XOR -> DONE, with cpu_load=1 for exactly one cycle on DONE entry, then cpu_hold=0 and boot_done=1.
  - Mismatch -> ERR.
- ERR: boot_err=1, cpu_hold stays 1, in_ready=1.
- Reload: in DONE or ERR, only HDR_BYTE is acted on; it restarts as from IDLE, including reasserting cpu_hold the cycle after acceptance. All other bytes are discarded.
- in_ready=1 in every state except WRITE; no byte is ever dropped while in_valid is held.
- imem_addr wraps only by being bounded by N; the write count never exceeds 2**ADDR_W.
- A reset mid-frame aborts immediately. IMEM contents already written are not rolled back, and the core stays held.
- Byte accepted on the same cycle as a state transition: the byte belongs to the state it was accepted in.

Optional Feature:
- Macro BOOT_TIMEOUT_EN.
- Defined: a counter clears on every accepted byte and runs in LEN/DATA/CSUM. Reaching TIMEOUT_CYC -> ERR with boot_err=1. IDLE/DONE/ERR never time out.
- Undefined: no counter; the loader waits indefinitely.

Decomposition:
- Shared package boot_pkg holds:
  - the state enum,
  - the HDR_BYTE default,
  - the checksum width,
  - the error-cause encoding: 0 bad length, 1 checksum, 2 timeout. This encoding is also exposable on the debug LED mux.
- One natural sub-module: boot_word_assembler, covering the byte shift register, byte index, and running XOR, with clear/shift/word_ready signals.

Test Plan:
- Frame A5,01,12,34,56,78,checksum 0x08:
  - imem_we pulses once with addr 0, wdata 32'h12345678.
  - cpu_load pulses once with cpu_pc_val=8'h00.
  - cpu_hold falls; boot_done=1.
- Frame A5,02, 8 payload bytes, wrong checksum: 2 writes (addr 0,1); boot_err=1; cpu_hold stays 1; cpu_load never pulses.
- Bytes 00,FF then A5,00: the leading bytes are ignored; LEN=0 -> boot_err=1; no imem_we.
- Max frame with N=64:
  - addresses 0..63 written in order; words_loaded=64; boot_done=1.
  - N=65 -> ERR at the LEN byte.
- Back-to-back in_valid held high: in_ready drops exactly one cycle after each 4th byte; all bytes transferred with none lost.
- Reload from DONE with a new frame: cpu_hold rises the cycle after A5; assert SYS_reset=0 mid-payload -> all outputs at reset values asynchronously.
- With BOOT_TIMEOUT_EN and TIMEOUT_CYC=100: stall 100 cycles in DATA -> ERR, boot_err=1.
